// File: rtl/perf_cnt_pckg.sv
// Purpose: shared constants for the perf-counter bank (counter geometry, CTRL bits, word map).
// Latency: n/a (constants and a pure address helper only).
// Backpressure: n/a. Optional feature macro PERF_CNT_SNAPSHOT_EN is consumed by perf_cnt_cell.
package perf_cnt_pckg;

  // Counter geometry
  localparam int C_PERF_CNT_WDT      = 48;
  localparam int C_PERF_CNT_WORD_CNT = 3;
  localparam int C_PERF_CNT_CNT      = 5;
  localparam int C_REG_WDT           = 32;

  // Counter index of each event source
  localparam int C_PERF_RUN_OFFS         = 0;
  localparam int C_PERF_COMP_OFFS        = 1;
  localparam int C_PERF_STREAM_C2H_OFFS  = 2;
  localparam int C_PERF_STREAM_H2C_OFFS  = 3;
  localparam int C_PERF_CACHE_STALL_OFFS = 4;

  // Byte address of counter 0 CTRL in the regmap
  localparam logic [31:0] C_PERF_RUN_CTRL_REG_ADDR = 32'h0000_0200;

  // CTRL word bit positions
  localparam int C_PERF_CTRL_EN_BIT  = 0;
  localparam int C_PERF_CTRL_CLR_BIT = 1;
  localparam int C_PERF_CTRL_OVF_BIT = 2;

  // Word offsets within one counter's three-word group
  localparam int C_PERF_WORD_CTRL = 0;
  localparam int C_PERF_WORD_L    = 1;
  localparam int C_PERF_WORD_UH   = 2;

  // Byte address of word 'word' of counter 'idx'
  function automatic logic [31:0] perf_word_addr(input logic [31:0] base,
                                                 input int          idx,
                                                 input int          word);
    return base + 32'((C_PERF_CNT_WORD_CNT * idx + word) * 4);
  endfunction

endpackage

// File: rtl/perf_cnt_cell.sv
// Purpose: one event counter with EN / self-clearing CLR / sticky OVF and an optional UH shadow.
// Latency: count and CTRL writes land at the sampling edge; outputs are straight from flops.
// Backpressure: none; every event cycle with EN=1 counts. Shadow built only with PERF_CNT_SNAPSHOT_EN.
module perf_cnt_cell #(
  parameter int C_CNT_WDT = perf_cnt_pckg::C_PERF_CNT_WDT,
  parameter int C_REG_WDT = perf_cnt_pckg::C_REG_WDT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           evt,
  input  logic                           ctrl_wr,
  input  logic                           wr_en_val,
  input  logic                           wr_clr,
  input  logic                           l_rd,
  output logic                           en,
  output logic                           ovf,
  output logic [C_REG_WDT-1:0]           lo_word,
  output logic [C_CNT_WDT-C_REG_WDT-1:0] hi_word
);
  import perf_cnt_pckg::*;

  localparam int C_HI_WDT = C_CNT_WDT - C_REG_WDT;

  logic [C_CNT_WDT-1:0] cnt;
  logic [C_CNT_WDT-1:0] cnt_nxt;
  logic                 ovf_nxt;

  // Next count: the current (pre-write) EN governs this cycle's event; CLR overrides everything
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (en && evt) begin
      cnt_nxt = cnt + C_CNT_WDT'(1);
      if (&cnt) begin
        ovf_nxt = 1'b1;
      end
    end
    if (ctrl_wr && wr_clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end
  end

  // Counter, overflow flag and enable state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
      en  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      if (ctrl_wr) begin
        en <= wr_en_val;
      end
    end
  end

  assign lo_word = cnt[C_REG_WDT-1:0];

`ifdef PERF_CNT_SNAPSHOT_EN
  logic [C_HI_WDT-1:0] shadow;

  // Capture the upper half when L is read so L-then-UH forms one coherent 48-bit sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (l_rd) begin
      shadow <= cnt[C_CNT_WDT-1:C_REG_WDT];
    end
  end

  assign hi_word = shadow;
`else
  logic unused_l_rd;
  assign unused_l_rd = l_rd;
  assign hi_word     = cnt[C_CNT_WDT-1:C_REG_WDT];
`endif

endmodule

// File: rtl/perf_cnt_bank.sv
// Purpose: bank of per-source perf counters behind a simple register read/write port.
// Latency: reads return one cycle after reg_rd_en (registered); writes apply at the strobe edge.
// Backpressure: none; a read may be issued every cycle. UH snapshot mode via PERF_CNT_SNAPSHOT_EN.
module perf_cnt_bank #(
  parameter int          C_PERF_CNT_CNT = perf_cnt_pckg::C_PERF_CNT_CNT,
  parameter int          C_PERF_CNT_WDT = perf_cnt_pckg::C_PERF_CNT_WDT,
  parameter int          C_REG_WDT      = perf_cnt_pckg::C_REG_WDT,
  parameter logic [31:0] C_BASE_ADDR    = perf_cnt_pckg::C_PERF_RUN_CTRL_REG_ADDR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [C_PERF_CNT_CNT-1:0] perf_evt_in,
  input  logic [31:0]               reg_addr,
  input  logic                      reg_wr_en,
  input  logic [C_REG_WDT-1:0]      reg_wr_data,
  input  logic                      reg_rd_en,
  output logic [C_REG_WDT-1:0]      reg_rd_data,
  output logic                      reg_rd_valid
);
  import perf_cnt_pckg::*;

  localparam int C_HI_WDT = C_PERF_CNT_WDT - C_REG_WDT;

  logic [C_PERF_CNT_CNT-1:0] hit_ctrl;
  logic [C_PERF_CNT_CNT-1:0] hit_l;
  logic [C_PERF_CNT_CNT-1:0] hit_uh;
  logic [C_PERF_CNT_CNT-1:0] ctrl_wr;
  logic [C_PERF_CNT_CNT-1:0] l_rd;
  logic [C_PERF_CNT_CNT-1:0] en;
  logic [C_PERF_CNT_CNT-1:0] ovf;
  logic [C_REG_WDT-1:0]      lo_word [C_PERF_CNT_CNT];
  logic [C_HI_WDT-1:0]       hi_word [C_PERF_CNT_CNT];
  logic [C_REG_WDT-1:0]      rd_mux;

  // Only CTRL EN and CLR are writable; the remaining write bits carry no meaning
  logic unused_wr_bits;
  assign unused_wr_bits = ^reg_wr_data[C_REG_WDT-1:2];

  // Exact-match decode of every mapped word; misaligned or out-of-range addresses hit nothing
  always_comb begin
    hit_ctrl = '0;
    hit_l    = '0;
    hit_uh   = '0;
    for (int i = 0; i < C_PERF_CNT_CNT; i++) begin
      hit_ctrl[i] = (reg_addr == perf_word_addr(C_BASE_ADDR, i, C_PERF_WORD_CTRL));
      hit_l[i]    = (reg_addr == perf_word_addr(C_BASE_ADDR, i, C_PERF_WORD_L));
      hit_uh[i]   = (reg_addr == perf_word_addr(C_BASE_ADDR, i, C_PERF_WORD_UH));
    end
  end

  assign ctrl_wr = {C_PERF_CNT_CNT{reg_wr_en}} & hit_ctrl;
  assign l_rd    = {C_PERF_CNT_CNT{reg_rd_en}} & hit_l;

  for (genvar gi = 0; gi < C_PERF_CNT_CNT; gi++) begin : g_cell
    perf_cnt_cell #(
      .C_CNT_WDT (C_PERF_CNT_WDT),
      .C_REG_WDT (C_REG_WDT)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .evt       (perf_evt_in[gi]),
      .ctrl_wr   (ctrl_wr[gi]),
      .wr_en_val (reg_wr_data[C_PERF_CTRL_EN_BIT]),
      .wr_clr    (reg_wr_data[C_PERF_CTRL_CLR_BIT]),
      .l_rd      (l_rd[gi]),
      .en        (en[gi]),
      .ovf       (ovf[gi]),
      .lo_word   (lo_word[gi]),
      .hi_word   (hi_word[gi])
    );
  end

  // Read mux over the one-hot decode; CLR always reads back as 0, unmapped reads as 0
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < C_PERF_CNT_CNT; i++) begin
      if (hit_ctrl[i]) begin
        rd_mux[C_PERF_CTRL_EN_BIT]  = en[i];
        rd_mux[C_PERF_CTRL_OVF_BIT] = ovf[i];
      end
      if (hit_l[i]) begin
        rd_mux = lo_word[i];
      end
      if (hit_uh[i]) begin
        rd_mux = C_REG_WDT'(hi_word[i]);
      end
    end
  end

  // Registered read response; data holds between reads, valid drops at once on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_rd_data  <= '0;
      reg_rd_valid <= 1'b0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      if (reg_rd_en) begin
        reg_rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_perf_cnt_bank.sv
// Purpose: directed self-checking bench for perf_cnt_bank (both PERF_CNT_SNAPSHOT_EN builds).
// Latency: checks the one-cycle registered read response.
// Backpressure: n/a; stimulus is a linear directed sequence.
module tb_perf_cnt_bank;

  localparam logic [31:0] BASE = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  perf_evt_in = '0;
  logic [31:0] reg_addr = '0;
  logic        reg_wr_en = 1'b0;
  logic [31:0] reg_wr_data = '0;
  logic        reg_rd_en = 1'b0;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid;

  int n_cmp = 0;
  int n_bad = 0;

  perf_cnt_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .perf_evt_in  (perf_evt_in),
    .reg_addr     (reg_addr),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_data  (reg_wr_data),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_valid (reg_rd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wa(input int i, input int w);
    return BASE + 32'((3 * i + w) * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    reg_addr  = a;
    reg_rd_en = 1'b1;
    @(posedge clk);
    #1;
    reg_rd_en = 1'b0;
    chk({tag, " vld"}, {31'b0, reg_rd_valid}, 32'h1);
    chk(tag, reg_rd_data, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_addr    = a;
    reg_wr_data = d;
    reg_wr_en   = 1'b1;
    @(posedge clk);
    #1;
    reg_wr_en = 1'b0;
  endtask

  task automatic pulse(input logic [4:0] m, input int n);
    @(negedge clk);
    perf_evt_in = m;
    repeat (n) @(posedge clk);
    #1;
    perf_evt_in = '0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst vld", {31'b0, reg_rd_valid}, 32'h0);
    chk("rst data", reg_rd_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // All 15 words read 0 after reset, back-to-back
    for (int i = 0; i < 5; i++) begin
      for (int w = 0; w < 3; w++) begin
        rd(wa(i, w), 32'h0, $sformatf("init c%0d w%0d", i, w));
      end
    end
    @(posedge clk);
    #1;
    chk("idle vld", {31'b0, reg_rd_valid}, 32'h0);

    // Counter 1 enabled, counter 0 disabled, both see 100 events
    wr(wa(1, 0), 32'h1);
    pulse(5'b00011, 100);
    rd(wa(1, 1), 32'd100, "c1 L");
    @(posedge clk);
    #1;
    chk("hold vld", {31'b0, reg_rd_valid}, 32'h0);
    chk("hold data", reg_rd_data, 32'd100);
    rd(wa(1, 2), 32'h0, "c1 UH");
    rd(wa(1, 0), 32'h1, "c1 CTRL");
    rd(wa(0, 1), 32'h0, "c0 L disabled");

    // Wrap: preload near the top, three events wrap to 1 and set OVF
    wr(wa(2, 0), 32'h1);
    @(negedge clk);
    force dut.g_cell[2].u_cell.cnt = 48'hFFFF_FFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.g_cell[2].u_cell.cnt;
    pulse(5'b00100, 3);
    rd(wa(2, 1), 32'h1, "c2 L wrap");
    rd(wa(2, 2), 32'h0, "c2 UH wrap");
    rd(wa(2, 0), 32'h5, "c2 CTRL ovf");
    wr(wa(2, 0), 32'h3);
    rd(wa(2, 1), 32'h0, "c2 L clr");
    rd(wa(2, 0), 32'h1, "c2 CTRL clr");

    // Snapshot: L read then an event carrying into the upper half
    wr(wa(3, 0), 32'h1);
    @(negedge clk);
    force dut.g_cell[3].u_cell.cnt = 48'h0000_FFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.g_cell[3].u_cell.cnt;
    rd(wa(3, 1), 32'hFFFF_FFFF, "c3 L pre");
    pulse(5'b01000, 1);
`ifdef PERF_CNT_SNAPSHOT_EN
    rd(wa(3, 2), 32'h0, "c3 UH snap");
`else
    rd(wa(3, 2), 32'h1, "c3 UH live");
`endif
    rd(wa(3, 1), 32'h0, "c3 L post");
    rd(wa(3, 2), 32'h1, "c3 UH post");

    // CLR in the same cycle as an event: CLR wins
    wr(wa(4, 0), 32'h1);
    pulse(5'b10000, 5);
    rd(wa(4, 1), 32'd5, "c4 L five");
    @(negedge clk);
    reg_addr    = wa(4, 0);
    reg_wr_data = 32'h3;
    reg_wr_en   = 1'b1;
    perf_evt_in = 5'b10000;
    @(posedge clk);
    #1;
    reg_wr_en   = 1'b0;
    perf_evt_in = '0;
    rd(wa(4, 1), 32'h0, "c4 L clr+evt");
    rd(wa(4, 0), 32'h1, "c4 CTRL clr+evt");

    // Read in the same cycle as an event returns the pre-increment value
    pulse(5'b10000, 7);
    @(negedge clk);
    reg_addr    = wa(4, 1);
    reg_rd_en   = 1'b1;
    perf_evt_in = 5'b10000;
    @(posedge clk);
    #1;
    reg_rd_en   = 1'b0;
    perf_evt_in = '0;
    chk("c4 rd+evt", reg_rd_data, 32'd7);
    rd(wa(4, 1), 32'd8, "c4 L after");

    // Disabling EN in the same cycle as an event: that event still counts
    @(negedge clk);
    reg_addr    = wa(4, 0);
    reg_wr_data = 32'h0;
    reg_wr_en   = 1'b1;
    perf_evt_in = 5'b10000;
    @(posedge clk);
    #1;
    reg_wr_en   = 1'b0;
    perf_evt_in = '0;
    pulse(5'b10000, 3);
    rd(wa(4, 1), 32'd9, "c4 L en off");

    // Read and write to the same CTRL word: read sees the pre-write value
    @(negedge clk);
    reg_addr    = wa(4, 0);
    reg_wr_data = 32'h1;
    reg_wr_en   = 1'b1;
    reg_rd_en   = 1'b1;
    @(posedge clk);
    #1;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    chk("c4 rdwr old", reg_rd_data, 32'h0);
    rd(wa(4, 0), 32'h1, "c4 rdwr new");

    // Writes to L/UH are ignored
    wr(wa(1, 1), 32'hDEAD_BEEF);
    wr(wa(1, 2), 32'h0000_BEEF);
    rd(wa(1, 1), 32'd100, "c1 L ro");
    rd(wa(1, 2), 32'h0, "c1 UH ro");

    // Unmapped addresses read 0 with valid; writes there change nothing
    rd(BASE + 32'h3C, 32'h0, "unmapped rd");
    rd(BASE + 32'h2, 32'h0, "misaligned rd");
    wr(BASE + 32'h3C, 32'hFFFF_FFFF);
    rd(wa(0, 0), 32'h0, "c0 CTRL untouched");
    rd(wa(1, 1), 32'd100, "c1 L untouched");

    // Reset in the middle of a read: valid drops immediately, state cleared
    @(negedge clk);
    reg_addr  = wa(1, 1);
    reg_rd_en = 1'b1;
    @(posedge clk);
    #1;
    chk("pre-rst vld", {31'b0, reg_rd_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst vld", {31'b0, reg_rd_valid}, 32'h0);
    chk("mid-rst data", reg_rd_data, 32'h0);
    reg_rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(wa(1, 1), 32'h0, "c1 L post-rst");
    rd(wa(1, 0), 32'h0, "c1 CTRL post-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
